// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back / write-allocate L2 with tree pseudo-LRU and byte-enable merge.
// Optional hit/miss counters are enabled by defining L2_PERF_COUNTERS_EN.
module l2_cache_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int s_way    = 2,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int s_mask   = 2**s_offset,
    parameter int s_line   = 8*s_mask
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    input  logic [s_line-1:0] mem_wdata256,
    input  logic [s_mask-1:0] mem_byte_enable256,
    output logic [s_line-1:0] mem_rdata256,
    output logic              mem_resp,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_line-1:0] pmem_wdata,
    output logic [31:0]       pmem_address
`ifdef L2_PERF_COUNTERS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int WAYS   = 2**s_way;
    localparam int SETS   = 2**s_index;
    localparam int NODES  = WAYS - 1;
    localparam int WAY_W  = s_way;
    localparam int NODE_W = s_way;
    localparam int LA_W   = s_tag + s_index;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

    state_t state_q, state_d;
    logic [LA_W-1:0]   addr_q, addr_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic [s_mask-1:0] be_q, be_d;
    logic              write_q, write_d;
    logic [WAY_W-1:0]  victim_q, victim_d;

    logic [SETS-1:0][WAYS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0][NODES-1:0] plru_q, plru_d;

    // Tag and data storage carry no reset; valid bits gate every use.
    logic [s_tag-1:0]  tag_arr  [SETS][WAYS];
    logic [s_line-1:0] data_arr [SETS][WAYS];

    logic              data_we, tag_we;
    logic [WAY_W-1:0]  data_way;
    logic [s_line-1:0] data_line;

    logic [s_index-1:0] idx;
    logic [s_tag-1:0]   req_tag;
    logic               hit, has_inv;
    logic [WAY_W-1:0]   hit_way, inv_way, plru_way, victim_way;
    logic [s_line-1:0]  hit_line, merged_line;
    logic [NODE_W-1:0]  vnode, unode;

    logic unused_offset;
    assign unused_offset = ^mem_address[s_offset-1:0];

    assign idx     = addr_q[s_index-1:0];
    assign req_tag = addr_q[LA_W-1 -: s_tag];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_arr[idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        hit_line = data_arr[idx][hit_way];
        for (int b = 0; b < s_mask; b++)
            merged_line[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : hit_line[8*b +: 8];
    end

    // Walk the tree from the root: a 0 bit sends the victim search to the lower half.
    always_comb begin
        vnode    = '0;
        plru_way = '0;
        for (int l = 0; l < s_way; l++) begin
            plru_way[s_way-1-l] = plru_q[idx][vnode];
            vnode = (vnode << 1) + NODE_W'(1) + NODE_W'(plru_q[idx][vnode]);
        end
        victim_way = has_inv ? inv_way : plru_way;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        write_d      = write_q;
        victim_d     = victim_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        plru_d       = plru_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        data_way     = '0;
        data_line    = '0;
        unode        = '0;
        mem_resp     = 1'b0;
        mem_rdata256 = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        pmem_address = '0;

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d  = mem_address[31:s_offset];
                    wdata_d = mem_wdata256;
                    be_d    = mem_byte_enable256;
                    write_d = mem_write;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    if (write_q) begin
                        data_we   = 1'b1;
                        data_way  = hit_way;
                        data_line = merged_line;
                        dirty_d[idx][hit_way] = 1'b1;
                    end else begin
                        mem_rdata256 = hit_line;
                    end
                    // Every node on the path points away from the way just used.
                    for (int l = 0; l < s_way; l++) begin
                        plru_d[idx][unode] = ~hit_way[s_way-1-l];
                        unode = (unode << 1) + NODE_W'(1) + NODE_W'(hit_way[s_way-1-l]);
                    end
                    state_d = IDLE;
                end else begin
                    victim_d = victim_way;
                    if (valid_q[idx][victim_way] && dirty_q[idx][victim_way])
                        state_d = WRITEBACK;
                    else
                        state_d = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[idx][victim_q], idx, {s_offset{1'b0}}};
                pmem_wdata   = data_arr[idx][victim_q];
                if (pmem_resp) begin
                    dirty_d[idx][victim_q] = 1'b0;
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, idx, {s_offset{1'b0}}};
                if (pmem_resp) begin
                    data_we   = 1'b1;
                    tag_we    = 1'b1;
                    data_way  = victim_q;
                    data_line = pmem_rdata;
                    valid_d[idx][victim_q] = 1'b1;
                    dirty_d[idx][victim_q] = 1'b0;
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            write_q  <= 1'b0;
            victim_q <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            plru_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            write_q  <= write_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            plru_q   <= plru_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_arr[idx][data_way] <= data_line;
        if (tag_we)  tag_arr[idx][data_way]  <= req_tag;
    end

`ifdef L2_PERF_COUNTERS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    logic        first_q, first_d;

    // Only the first COMPARE of a request is counted; the post-fill re-entry is not.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        first_d      = first_q;
        if (state_q == IDLE && (mem_read || mem_write))
            first_d = 1'b1;
        if (state_q == COMPARE) begin
            first_d = 1'b0;
            if (hit && first_q && hit_count_q != '1)
                hit_count_d = hit_count_q + 32'd1;
            if (!hit && miss_count_q != '1)
                miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            first_q      <= 1'b0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            first_q      <= first_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_l2_cache_nway.sv
// Bench for l2_cache_nway: directed scenarios then random traffic against a line-level reference model.
module tb_l2_cache_nway;

    typedef logic [255:0] line_t;
    localparam int WAYS = 4;
    localparam int SETS = 8;

    logic        clk, rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_address;
    line_t       mem_wdata256, mem_rdata256, pmem_rdata, pmem_wdata;
    logic [31:0] mem_byte_enable256;
    logic        mem_resp, pmem_resp, pmem_read, pmem_write;
    logic [31:0] pmem_address;
`ifdef L2_PERF_COUNTERS_EN
    logic [31:0] hit_count, miss_count;
`endif

    l2_cache_nway dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256),
        .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_address(pmem_address)
`ifdef L2_PERF_COUNTERS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_miss = 0;

    // Reference: flat memory view seen by upstream, backing store behind the EWB, and per-set cache state.
    line_t       ref_mem [logic [31:0]];
    line_t       ewb_mem [logic [31:0]];
    logic [23:0] m_tag   [SETS][WAYS];
    bit          m_val   [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    bit          m_plru  [SETS][WAYS-1];
    int          exp_hits, exp_misses;

    int    r_lat, r_wb_cnt, r_fill_cnt, r_first_pmem;
    bit    r_timeout, r_both, r_unstable, r_long;
    logic [31:0] r_wb_addr, r_fill_addr;
    line_t r_wb_data, r_rdata;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    function automatic line_t init_line(input logic [31:0] a);
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = a ^ (32'h1111_1111 * i) ^ 32'h5A00_0000;
        return l;
    endfunction

    function automatic line_t ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    function automatic line_t ewb_get(input logic [31:0] a);
        return ewb_mem.exists(a) ? ewb_mem[a] : init_line(a);
    endfunction

    function automatic int plru_victim(input int s);
        int lo = 0, hi = WAYS, node = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (!m_plru[s][node]) begin hi = mid; node = 2*node + 1; end
            else                  begin lo = mid; node = 2*node + 2; end
        end
        return lo;
    endfunction

    task automatic plru_touch(input int s, input int w);
        int lo = 0, hi = WAYS, node = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin m_plru[s][node] = 1'b1; hi = mid; node = 2*node + 1; end
            else         begin m_plru[s][node] = 1'b0; lo = mid; node = 2*node + 2; end
        end
    endtask

    // Cache contents are lost on reset; upstream then sees whatever the EWB holds.
    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin m_val[s][w] = 0; m_dirty[s][w] = 0; end
            for (int n = 0; n < WAYS-1; n++) m_plru[s][n] = 0;
        end
        ref_mem.delete();
        foreach (ewb_mem[k]) ref_mem[k] = ewb_mem[k];
        exp_hits = 0;
        exp_misses = 0;
    endtask

    // Drives one request to completion while acting as the EWB (3-cycle response latency).
    task automatic do_req(input bit wr, input logic [31:0] addr, input line_t wd, input logic [31:0] be);
        int dly = 0;
        bit got = 0;
        logic [31:0] cur_a = '0;
        mem_read = !wr; mem_write = wr; mem_address = addr;
        mem_wdata256 = wd; mem_byte_enable256 = be;
        r_lat = 0; r_wb_cnt = 0; r_fill_cnt = 0; r_first_pmem = -1;
        r_timeout = 0; r_both = 0; r_unstable = 0; r_long = 0;
        r_wb_addr = '0; r_fill_addr = '0; r_wb_data = '0; r_rdata = '0;
        while (!got && r_lat < 100) begin
            @(negedge clk);
            r_lat++;
            if (pmem_read && pmem_write) r_both = 1;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                dly = 0;
            end else if (pmem_read || pmem_write) begin
                if (dly == 0) begin
                    cur_a = pmem_address;
                    if (r_first_pmem < 0) r_first_pmem = r_lat;
                    if (pmem_write) begin r_wb_cnt++; r_wb_addr = pmem_address; r_wb_data = pmem_wdata; end
                    else begin r_fill_cnt++; r_fill_addr = pmem_address; end
                end else if (pmem_address !== cur_a || (pmem_write && pmem_wdata !== r_wb_data)) begin
                    r_unstable = 1;
                end
                dly++;
                if (dly == 3) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) ewb_mem[pmem_address] = pmem_wdata;
                    else pmem_rdata = ewb_get(pmem_address);
                end
            end
            if (mem_resp) begin got = 1; r_rdata = mem_rdata256; end
        end
        if (!got) r_timeout = 1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        if (mem_resp) r_long = 1;
    endtask

    task automatic req(input string tag, input bit wr, input logic [31:0] addr, input line_t wd,
                       input logic [31:0] be);
        int s, hw, v, exp_lat;
        logic [23:0] t;
        logic [31:0] la, wb_a;
        bit exp_wb, miss;
        line_t wb_d, cur;
        la = {addr[31:5], 5'b0};
        s = int'(addr[7:5]);
        t = addr[31:8];
        hw = -1;
        for (int w = 0; w < WAYS; w++) if (hw < 0 && m_val[s][w] && m_tag[s][w] == t) hw = w;
        exp_wb = 0; wb_a = '0; wb_d = '0;
        miss = (hw < 0);
        if (!miss) begin
            exp_lat = 1;
            exp_hits++;
        end else begin
            v = -1;
            for (int w = 0; w < WAYS; w++) if (v < 0 && !m_val[s][w]) v = w;
            if (v < 0) v = plru_victim(s);
            if (m_val[s][v] && m_dirty[s][v]) begin
                exp_wb = 1;
                wb_a = {m_tag[s][v], addr[7:5], 5'b0};
                wb_d = ref_get(wb_a);
            end
            exp_lat = exp_wb ? 9 : 5;
            m_tag[s][v] = t; m_val[s][v] = 1; m_dirty[s][v] = 0;
            hw = v;
            exp_misses++;
        end
        plru_touch(s, hw);
        if (wr) begin
            cur = ref_get(la);
            for (int b = 0; b < 32; b++) if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
            ref_mem[la] = cur;
            m_dirty[s][hw] = 1;
        end

        do_req(wr, addr, wd, be);

        chk({tag, "_proto"}, {r_timeout, r_both, r_unstable, r_long}, 4'b0);
        chk({tag, "_lat"}, r_lat, exp_lat);
        chk({tag, "_wbcnt"}, r_wb_cnt, exp_wb);
        if (exp_wb) begin
            chk({tag, "_wbaddr"}, r_wb_addr, wb_a);
            chk({tag, "_wbdata"}, r_wb_data, wb_d);
        end
        chk({tag, "_fillcnt"}, r_fill_cnt, miss);
        if (miss) begin
            chk({tag, "_filladdr"}, r_fill_addr, la);
            chk({tag, "_pmemrise"}, r_first_pmem, 2);
        end
        if (!wr) chk({tag, "_rdata"}, r_rdata, ref_get(la));
    endtask

    task automatic stray_resp();
        pmem_resp = 1'b1;
        pmem_rdata = {8{$urandom()}};
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    function automatic line_t rnd_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
        return l;
    endfunction

    initial begin
        line_t       wd;
        logic [31:0] a, be;
        int          k;
        rst = 1'b1;
        mem_read = 0; mem_write = 0; mem_address = '0;
        mem_wdata256 = '0; mem_byte_enable256 = '0;
        pmem_rdata = '0; pmem_resp = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_mem_resp", mem_resp, 1'b0);
        chk("rst_pmem_rw", {pmem_read, pmem_write}, 2'b00);
        chk("rst_pmem_addr", pmem_address, 32'h0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        chk("rst_rdata", mem_rdata256, '0);
`ifdef L2_PERF_COUNTERS_EN
        chk("rst_counters", {hit_count, miss_count}, 64'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Cold read, repeat hit, partial write, read-back of the merge.
        req("s1_cold", 0, 32'h0000_1040, '0, '0);
        chk("s1_filladdr_abs", r_fill_addr, 32'h0000_1040);
        chk("s1_line_a", r_rdata, init_line(32'h0000_1040));
        req("s2_hit", 0, 32'h0000_1040, '0, '0);
        wd = rnd_line();
        wd[31:0] = 32'hDEAD_BEEF;
        req("s3_write", 1, 32'h0000_1040, wd, 32'h0000_000F);
`ifdef L2_PERF_COUNTERS_EN
        chk("perf_hits", hit_count, 32'd2);
        chk("perf_misses", miss_count, 32'd1);
`endif
        req("s3_read", 0, 32'h0000_1044, '0, '0);
        chk("s3_word0", r_rdata[31:0], 32'hDEAD_BEEF);
        chk("s3_upper", r_rdata[255:32], init_line(32'h0000_1040) >> 32);
        stray_resp();
        req("stray_hit", 0, 32'h0000_1040, '0, '0);

        // Fill set 2 with way 0 dirty, then force a PLRU eviction.
        do_reset();
        req("s4_r040", 0, 32'h0000_0040, '0, '0);
        req("s4_w040", 1, 32'h0000_0040, rnd_line(), 32'hFFFF_0F0F);
        req("s4_r140", 0, 32'h0000_0140, '0, '0);
        req("s4_w140_be0", 1, 32'h0000_0140, rnd_line(), 32'h0);
        req("s4_r240", 0, 32'h0000_0240, '0, '0);
        req("s4_r340", 0, 32'h0000_0340, '0, '0);
        req("s4_r440", 0, 32'h0000_0440, '0, '0);
        chk("s4_wb_abs", r_wb_addr, 32'h0000_0040);
        req("s4_r040_again", 0, 32'h0000_0040, '0, '0);

        // Reset while a fill is outstanding.
        mem_read = 1'b1; mem_address = 32'h0000_2060;
        k = 0;
        while (!pmem_read && k < 20) begin @(negedge clk); k++; end
        chk("rf_seen_fill", pmem_read, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rf_pmem_read", pmem_read, 1'b0);
        chk("rf_others", {pmem_write, mem_resp}, 2'b00);
        chk("rf_pmem_addr", pmem_address, 32'h0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        req("rf_remiss", 0, 32'h0000_2060, '0, '0);
        req("rf_evicted_dirty", 0, 32'h0000_1040, '0, '0);

        // Random traffic over two sets and six tags to keep evictions frequent.
        for (int i = 0; i < 300; i++) begin
            a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 1)) << 5) |
                32'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0: be = '0;
                1: be = '1;
                default: be = $urandom();
            endcase
            if ($urandom_range(0, 15) == 0) stray_resp();
            req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, rnd_line(), be);
        end
`ifdef L2_PERF_COUNTERS_EN
        chk("perf_hits_end", hit_count, 32'(exp_hits));
        chk("perf_misses_end", miss_count, 32'(exp_misses));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
